pipe_stage_buffer: RTL



---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_stage_buffer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Control bundles are packed LSB-first using the *_LSB offsets below; every
// NOP constant leaves branch, jump, memory-write and register-write inactive.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // ID/EX bundle layout
  localparam int IDEX_ALU_OP_LSB  = 0;   // 4 bits
  localparam int IDEX_ALU_SRC_LSB = 4;
  localparam int IDEX_BRANCH_LSB  = 5;
  localparam int IDEX_JUMP_LSB    = 6;
  localparam int IDEX_MEM_RD_LSB  = 7;
  localparam int IDEX_MEM_WR_LSB  = 8;
  localparam int IDEX_WB_SEL_LSB  = 9;   // 2 bits
  localparam int IDEX_REG_WE_LSB  = 11;
  localparam int IDEX_RD_LSB      = 12;  // 5 bits
  localparam int IDEX_SIZE_LSB    = 17;  // 3 bits, 20..23 spare

  localparam int IDEX_CTRL_W  = 24;
  localparam int EXMEM_CTRL_W = 13;  // mem_rd, mem_wr, wb_sel, reg_we, rd, size
  localparam int MEMWB_CTRL_W = 8;   // wb_sel, reg_we, rd

  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

  // True when a bundle would cause an architectural side effect.
  function automatic logic idex_has_effect(input logic [IDEX_CTRL_W-1:0] ctrl);
    return ctrl[IDEX_BRANCH_LSB] | ctrl[IDEX_JUMP_LSB] |
           ctrl[IDEX_MEM_WR_LSB] | ctrl[IDEX_REG_WE_LSB];
  endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Handshaked pipeline stage register with flush and bubble-to-NOP.
// Build option PIPE_STAGE_SKID_EN: adds a second (skid) entry so IN_READY is
// decoded from registered state only. Without it the stage holds one entry
// and IN_READY passes OUT_READY through combinationally.
//
// state | meaning
// EMPTY | no valid entry, OUT_CTRL forced to CTRL_NOP
// ONE   | main entry valid and presented
// TWO   | main and skid valid, upstream stalled (skid build only)
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int                   DATA_W   = 96,
  parameter int                   CTRL_W   = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0]    CTRL_NOP = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  input  logic              OUT_READY,
  output logic [1:0]        OCCUPANCY
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
`endif

  logic accept;
  logic drain;

  // Handshake decode and presented outputs
  always_comb begin
    OUT_VALID = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    IN_READY  = (state_q != TWO);
`else
    IN_READY  = (state_q == EMPTY) | OUT_READY;
`endif
    accept    = IN_VALID & IN_READY;
    drain     = OUT_VALID & OUT_READY;
    OUT_DATA  = main_data_q;
    OUT_CTRL  = OUT_VALID ? main_ctrl_q : CTRL_NOP;
    unique case (state_q)
      ONE:     OCCUPANCY = 2'd1;
      TWO:     OCCUPANCY = 2'd2;
      default: OCCUPANCY = 2'd0;
    endcase
  end

  // Next-state and entry-load logic; flush overrides every transition
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_data_d = IN_DATA;
            skid_ctrl_d = IN_CTRL;
            state_d     = TWO;
`endif
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (drain) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
`endif
    end
  end

endmodule
